cdc_rr_arbiter: RTL
===================

// Module: cdc_rr_arbiter
// PURPOSE
//  N-channel clock-domain-crossing collector and round-robin arbiter. Each asynchronous source
//  holds a data word stable and raises a level request. The block synchronises the request,
//  arbitrates between pending channels, and loads the winner's word into a single registered
//  valid/ready output. It completes a 4-phase req/ack handshake back to each source.
//  Sits between several slow/async producers and one clk-domain consumer.
// PARAMETERS
//  NCH     4  number of source channels (>=2)
//  DWIDTH  8  data word width per channel
//  STAGES  2  synchroniser flip-flops per request line (>=2)
// PORTS
//  clk         in   1            clock
//  rst         in   1            synchronous reset, active-high
//  req_i       in   NCH          async level request per channel
//  din_i       in   NCH*DWIDTH   async data; channel c = din_i[c*DWIDTH +: DWIDTH]
//  ack_o       out  NCH          level acknowledge per channel (registered)
//  dout        out  DWIDTH       granted data word (registered)
//  dout_ch     out  CW           index of channel that produced dout; CW = max(1,$clog2(NCH))
//  dout_valid  out  1            dout/dout_ch valid
//  dout_ready  in   1            consumer accepts when dout_valid && dout_ready
// BEHAVIOUR
//  Reset (rst=1 at posedge): sync chains=0, all channel FSMs=IDLE, ack_o=0, dout=0, dout_ch=0,
//    dout_valid=0, rr pointer last_grant=NCH-1 (channel 0 has first priority).
//  Sync: req_i[c] -> STAGES-flop chain (ASYNC_REG); req_s[c] = last stage. No other async input is
//    registered. din_i is sampled only at grant; the source keeps it stable from req rise until ack seen.
//  Per-channel FSM (ack_o[c] = (state==ACK)):
//    IDLE -> PEND  when req_s=1
//    PEND -> ACK   when granted (same edge the word loads into dout)
//    PEND -> IDLE  when req_s=0 before grant (abort: no output, no ack)
//    ACK  -> IDLE  when req_s=0 (ack_o drops on that edge)
//    ACK ignores req_s=1. A new word requires req to go low and then high again.
//  Output slot: load_en = (!dout_valid || dout_ready) && any PEND.
//    On load_en: dout <= din slice of winner, dout_ch <= winner, dout_valid <= 1, last_grant <= winner.
//    Else if dout_valid && dout_ready: dout_valid <= 0. Otherwise hold dout/dout_ch/dout_valid.
//    Accept and reload in the same cycle keeps dout_valid=1 (back-to-back, 1 word/cycle max).
//  Arbitration: among PEND channels, first found searching last_grant+1, +2, ... modulo NCH.
//    Exactly one grant per load. A channel being aborted (PEND with req_s=0) is not eligible.
//  Latency: req_i high ahead of edge 1 -> req_s high after edge STAGES -> PEND after STAGES+1 ->
//    dout_valid & ack_o high after edge STAGES+2 (4 edges at STAGES=2) if slot free.
//    req_i low -> ack_o low after STAGES+1 edges.
//  Backpressure: while dout_valid && !dout_ready, PEND channels wait. Their ack_o stays 0.
//  Reset mid-operation overrides everything next edge. A source still holding req high is
//    re-serviced as a new request (duplicate word permitted, by design).
// TESTING
//  1 ch1 req_i=1, din ch1=8'hA5, ready=1 -> after 4 edges dout_valid=1, dout=A5, dout_ch=1,
//    ack_o=4'b0010. Drop req_i[1] -> ack_o[1]=0 exactly 3 edges later.
//  2 req_i=4'b1111 same edge, words 11/22/33/44, ready=1 -> dout 11,22,33,44 on consecutive cycles,
//    ch 0,1,2,3. Each ack_o rises on its load edge.
//  3 ch2 loaded, ready=0 for 10 cycles, ch3 pending -> dout holds ch2 word, ch3 ack_o=0.
//    Ready=1 -> ch3 loaded next edge, dout_valid stays 1.
//  4 ch0 re-requests continuously, ch3 pending -> grants alternate 0,3,0,3. ch0 never wins twice while ch3 waits.
//  5 ch1 req pulse dropped while PEND (ready=0) -> no dout for ch1, ack_o[1] never asserts, FSM back to IDLE.
//  6 rst=1 while ch2 in ACK with dout_valid=1 -> next edge ack_o=0, dout_valid=0, dout=0.
//    With req_i[2] still 1 after release -> re-delivered after 4 edges.

Source files
------------

// File: rtl/cdc_rr_arbiter.sv
// Collects words from asynchronous level-request sources, synchronises each request,
// round-robin arbitrates pending channels into one registered valid/ready slot and returns a 4-phase ack.
module cdc_rr_arbiter #(
  parameter  int unsigned NCH    = 4,
  parameter  int unsigned DWIDTH = 8,
  parameter  int unsigned STAGES = 2,
  localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_i,
  input  logic [NCH*DWIDTH-1:0]   din_i,
  output logic [NCH-1:0]          ack_o,
  output logic [DWIDTH-1:0]       dout,
  output logic [CW-1:0]           dout_ch,
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } ch_state_e;

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q [NCH];

  ch_state_e         state_q [NCH];
  logic [NCH-1:0]    ack_q;
  logic [NCH-1:0]    req_s;
  logic [NCH-1:0]    eligible;
  logic [CW-1:0]     last_grant_q;
  logic [CW-1:0]     winner;
  logic              found;
  logic              load_en;
  logic [DWIDTH-1:0] dout_q;
  logic [CW-1:0]     dout_ch_q;
  logic              dout_valid_q;

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (rst) begin
        sync_q[c] <= '0;
      end else begin
        sync_q[c] <= {sync_q[c][STAGES-2:0], req_i[c]};
      end
    end
  end

  // A channel that is PEND but whose request has already dropped is aborting, not eligible.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      req_s[c]    = sync_q[c][STAGES-1];
      eligible[c] = (state_q[c] == PEND) && req_s[c];
    end
  end

  always_comb begin
    int unsigned idx;
    logic [CW-1:0] idx_w;
    idx    = 0;
    idx_w  = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = 32'(last_grant_q) + i;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      idx_w = CW'(idx);
      if (!found && eligible[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign load_en = (!dout_valid_q || dout_ready) && found;

  // ack has its own flop so the level seen by the async source never glitches on state decode.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (rst) begin
        state_q[c] <= IDLE;
        ack_q[c]   <= 1'b0;
      end else begin
        unique case (state_q[c])
          IDLE: begin
            if (req_s[c]) begin
              state_q[c] <= PEND;
            end
          end
          PEND: begin
            if (!req_s[c]) begin
              state_q[c] <= IDLE;
            end else if (load_en && (winner == CW'(c))) begin
              state_q[c] <= ACK;
              ack_q[c]   <= 1'b1;
            end
          end
          ACK: begin
            if (!req_s[c]) begin
              state_q[c] <= IDLE;
              ack_q[c]   <= 1'b0;
            end
          end
          default: begin
            state_q[c] <= IDLE;
            ack_q[c]   <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      last_grant_q <= CW'(NCH - 1);
    end else if (load_en) begin
      dout_q       <= din_i[32'(winner)*DWIDTH +: DWIDTH];
      dout_ch_q    <= winner;
      dout_valid_q <= 1'b1;
      last_grant_q <= winner;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign ack_o      = ack_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;

endmodule
